led_pwm_driver: RTL and testbench

Wishbone-slave LED controller: parametrised successor of the byte-register LED driver. Drives NUM_LEDS outputs, each with its own PWM duty, plus a global prescaler and optional blink gating. Sits on the peripheral Wishbone bus beside the other memory-mapped peripherals; its outputs go straight to board LEDs.

---
 rtl/led_pwm_driver_if.sv | 24 ++
 rtl/led_pwm_driver.sv | 159 +++++++++++++++
 tb/tb_led_pwm_driver.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pwm_driver_if.sv
// Wishbone slave bundle for the LED PWM driver.
// Signal names keep the _i/_o suffixes as seen from the slave.
interface led_pwm_driver_if #(
    parameter int ADR_W = 4
);
    logic             wb_cyc_i;
    logic             wb_stb_i;
    logic             wb_we_i;
    logic             wb_ack_o;
    logic [3:0]       wb_sel_i;
    logic [ADR_W-1:0] wb_adr_i;
    logic [31:0]      wb_dat_i;
    logic [31:0]      wb_dat_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_ack_o, wb_dat_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_ack_o, wb_dat_o
    );
endinterface

// File: rtl/led_pwm_driver.sv
// Wishbone-mapped LED controller: per-channel PWM duty with frame-aligned
// duty shadowing, a global prescaler and optional blink gating.
module led_pwm_driver #(
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = 8,
    parameter int ADR_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    led_pwm_driver_if.slave     wb,
    output logic [NUM_LEDS-1:0] leds
);
    localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;
    localparam int                  DUTY_BASE = 4;

    logic [1:0]          ctrl_q, ctrl_d;
    logic [15:0]         prescale_q, prescale_d;
    logic [15:0]         blink_period_q, blink_period_d;
    logic [PWM_BITS-1:0] duty_q   [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_d   [NUM_LEDS];
    logic [PWM_BITS-1:0] active_q [NUM_LEDS];
    logic [PWM_BITS-1:0] active_d [NUM_LEDS];
    logic                pending_q, pending_d;
    logic                phase_q, phase_d;
    logic [15:0]         pcnt_q, pcnt_d;
    logic [15:0]         fcnt_q, fcnt_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;

    logic        req;
    logic        wr;
    logic        tick;
    logic        frame_end;
    logic        blink_on;
    logic        duty_wr;
    logic [31:0] rdata;

    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    assign req       = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr        = req & wb.wb_we_i;
    assign tick      = (pcnt_q >= prescale_q);
    assign frame_end = tick & (pwm_q == PWM_MAX);
    assign blink_on  = ctrl_q[1] & (blink_period_q != 16'd0);

    always_comb begin
        rdata = '0;
        case (wb.wb_adr_i)
            ADR_W'(0): rdata[1:0]  = ctrl_q;
            ADR_W'(1): rdata[15:0] = prescale_q;
            ADR_W'(2): rdata[15:0] = blink_period_q;
            ADR_W'(3): rdata[1:0]  = {pending_q, phase_q};
            default: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (wb.wb_adr_i == ADR_W'(DUTY_BASE + i)) rdata[PWM_BITS-1:0] = duty_q[i];
                end
            end
        endcase
    end

    always_comb begin
        ack_d          = req;
        dat_d          = req ? rdata : dat_q;
        ctrl_d         = ctrl_q;
        prescale_d     = prescale_q;
        blink_period_d = blink_period_q;
        duty_wr        = 1'b0;
        if (wr && wb.wb_adr_i == ADR_W'(0))
            ctrl_d = 2'(lane_merge(32'(ctrl_q), wb.wb_dat_i, wb.wb_sel_i));
        if (wr && wb.wb_adr_i == ADR_W'(1))
            prescale_d = 16'(lane_merge(32'(prescale_q), wb.wb_dat_i, wb.wb_sel_i));
        if (wr && wb.wb_adr_i == ADR_W'(2))
            blink_period_d = 16'(lane_merge(32'(blink_period_q), wb.wb_dat_i, wb.wb_sel_i));
        for (int i = 0; i < NUM_LEDS; i++) begin
            duty_d[i]   = duty_q[i];
            active_d[i] = frame_end ? duty_q[i] : active_q[i];
            if (wr && wb.wb_adr_i == ADR_W'(DUTY_BASE + i)) begin
                duty_d[i] = PWM_BITS'(lane_merge(32'(duty_q[i]), wb.wb_dat_i, wb.wb_sel_i));
                duty_wr   = 1'b1;
            end
        end
        // A duty write on the frame-end cycle must survive the clear.
        pending_d = (pending_q & ~frame_end) | duty_wr;
    end

    always_comb begin
        pcnt_d  = tick ? 16'd0 : pcnt_q + 16'd1;
        pwm_d   = tick ? pwm_q + PWM_BITS'(1) : pwm_q;
        phase_d = phase_q;
        fcnt_d  = fcnt_q;
        if (!blink_on) begin
            phase_d = 1'b1;
            fcnt_d  = 16'd0;
        end else if (frame_end) begin
            // fcnt past the period (after shrinking it) restarts without a toggle.
            if (fcnt_q >= blink_period_q - 16'd1) begin
                fcnt_d = 16'd0;
                if (fcnt_q == blink_period_q - 16'd1) phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 16'd1;
            end
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
            leds_d[i] = ctrl_q[0] & phase_q &
                        ((pwm_q < active_q[i]) | (active_q[i] == PWM_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q         <= '0;
            prescale_q     <= '0;
            blink_period_q <= '0;
            pending_q      <= 1'b0;
            phase_q        <= 1'b1;
            pcnt_q         <= '0;
            fcnt_q         <= '0;
            pwm_q          <= '0;
            ack_q          <= 1'b0;
            dat_q          <= '0;
            leds_q         <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty_q[i]   <= '0;
                active_q[i] <= '0;
            end
        end else begin
            ctrl_q         <= ctrl_d;
            prescale_q     <= prescale_d;
            blink_period_q <= blink_period_d;
            pending_q      <= pending_d;
            phase_q        <= phase_d;
            pcnt_q         <= pcnt_d;
            fcnt_q         <= fcnt_d;
            pwm_q          <= pwm_d;
            ack_q          <= ack_d;
            dat_q          <= dat_d;
            leds_q         <= leds_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty_q[i]   <= duty_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign leds        = leds_q;
endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench for led_pwm_driver: directed scenarios plus random bus
// traffic, every cycle compared against a behavioural model of the register map.
module tb_led_pwm_driver;
    localparam int NUM_LEDS = 8;
    localparam int PWM_BITS = 8;
    localparam int ADR_W    = 4;
    localparam int MAXP     = (1 << PWM_BITS) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_LEDS-1:0] leds;

    int checks   = 0;
    int failures = 0;

    led_pwm_driver_if #(.ADR_W(ADR_W)) bus ();

    led_pwm_driver #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(PWM_BITS), .ADR_W(ADR_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .wb   (bus.slave),
        .leds (leds)
    );

    always #5 clk = ~clk;

    // Behavioural model state, plain integers for every register and counter.
    int                  m_ctrl, m_pre, m_bper, m_pcnt, m_pwm, m_fcnt, m_phase, m_pend;
    int                  m_duty [NUM_LEDS];
    int                  m_act  [NUM_LEDS];
    logic                m_ack;
    logic [31:0]         m_dat;
    logic [NUM_LEDS-1:0] m_leds;
    logic                prev_ack = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int merge(input int old, input logic [31:0] d, input logic [3:0] s, input int mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return int'(r) & mask;
    endfunction

    // One clock of the reference behaviour; all decisions use pre-edge values.
    task automatic modelStep();
        bit req, tick, fe;
        int adr, rd;
        if (rst) begin
            m_ctrl = 0; m_pre = 0; m_bper = 0; m_pcnt = 0; m_pwm = 0;
            m_fcnt = 0; m_phase = 1; m_pend = 0;
            for (int i = 0; i < NUM_LEDS; i++) begin m_duty[i] = 0; m_act[i] = 0; end
            m_ack = 0; m_dat = 0; m_leds = 0;
            return;
        end
        req  = bus.wb_cyc_i && bus.wb_stb_i && !m_ack;
        adr  = int'(bus.wb_adr_i);
        tick = (m_pcnt >= m_pre);
        fe   = tick && (m_pwm == MAXP);
        for (int i = 0; i < NUM_LEDS; i++)
            m_leds[i] = (m_ctrl & 1) != 0 && m_phase != 0 && (m_pwm < m_act[i] || m_act[i] == MAXP);
        rd = 0;
        if (adr == 0) rd = m_ctrl;
        else if (adr == 1) rd = m_pre;
        else if (adr == 2) rd = m_bper;
        else if (adr == 3) rd = m_phase + 2 * m_pend;
        else if (adr >= 4 && adr < 4 + NUM_LEDS) rd = m_duty[adr - 4];
        m_ack = req;
        if (req) m_dat = rd;
        if ((m_ctrl & 2) != 0 && m_bper != 0) begin
            if (fe) begin
                m_fcnt = m_fcnt + 1;
                if (m_fcnt == m_bper) begin
                    m_phase = 1 - m_phase;
                    m_fcnt  = 0;
                end else if (m_fcnt > m_bper) begin
                    m_fcnt = 0;
                end
            end
        end else begin
            m_fcnt  = 0;
            m_phase = 1;
        end
        m_pcnt = tick ? 0 : m_pcnt + 1;
        if (tick) m_pwm = (m_pwm + 1) % (MAXP + 1);
        if (fe) begin
            for (int i = 0; i < NUM_LEDS; i++) m_act[i] = m_duty[i];
            m_pend = 0;
        end
        if (req && bus.wb_we_i) begin
            if (adr == 0) m_ctrl = merge(m_ctrl, bus.wb_dat_i, bus.wb_sel_i, 3);
            else if (adr == 1) m_pre = merge(m_pre, bus.wb_dat_i, bus.wb_sel_i, 'hFFFF);
            else if (adr == 2) m_bper = merge(m_bper, bus.wb_dat_i, bus.wb_sel_i, 'hFFFF);
            else if (adr >= 4 && adr < 4 + NUM_LEDS) begin
                m_duty[adr - 4] = merge(m_duty[adr - 4], bus.wb_dat_i, bus.wb_sel_i, MAXP);
                m_pend = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    // Compare every DUT output with the model on each falling edge.
    initial forever begin
        @(negedge clk);
        checkOutput("leds", 32'(leds), 32'(m_leds));
        checkOutput("ack", 32'(bus.wb_ack_o), 32'(m_ack));
        checkOutput("dat_o", bus.wb_dat_o, m_dat);
        checkOutput("ack_gap", 32'(prev_ack & bus.wb_ack_o), 32'd0);
        prev_ack = bus.wb_ack_o;
    end

    task automatic applyStimulus(input logic we, input int adr, input logic [3:0] sel,
                                 input logic [31:0] dat, output logic [31:0] rdat);
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = ADR_W'(adr);
        bus.wb_sel_i = sel;
        bus.wb_dat_i = dat;
        @(negedge clk);
        checkOutput("xfer_ack", 32'(bus.wb_ack_o), 32'd1);
        rdat = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic countHigh(input int idx, input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (leds[idx]) n++;
        end
    endtask

    initial begin
        logic [31:0] rdat;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          n;
        int          adr;
        logic        we;

        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_sel_i = '0;
        bus.wb_dat_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset readback");
        for (int a = 0; a < 5; a++) begin
            applyStimulus(1'b0, a, 4'h0, 32'h0, rdat);
            // Blink phase resets to ON, so STATUS reads 1.
            checkOutput($sformatf("reset_rd%0d", a), rdat, (a == 3) ? 32'd1 : 32'd0);
        end
        checkOutput("reset_leds", 32'(leds), 32'd0);

        $display("[TB] duty 0x40 on channel 0");
        applyStimulus(1'b1, 4, 4'b0001, 32'h0000_0040, rdat);
        applyStimulus(1'b1, 0, 4'b1111, 32'h1, rdat);
        applyStimulus(1'b1, 1, 4'b1111, 32'h0, rdat);
        applyStimulus(1'b0, 3, 4'h0, 32'h0, rdat);
        checkOutput("status_pending", rdat, 32'd3);
        repeat (300) @(negedge clk);
        applyStimulus(1'b0, 3, 4'h0, 32'h0, rdat);
        checkOutput("status_loaded", rdat, 32'd1);
        countHigh(0, 256, n);
        checkOutput("duty40_high", 32'(n), 32'd64);

        $display("[TB] full and zero duty");
        applyStimulus(1'b1, 5, 4'b1111, 32'hFF, rdat);
        applyStimulus(1'b1, 6, 4'b1111, 32'h00, rdat);
        repeat (300) @(negedge clk);
        countHigh(1, 768, n);
        checkOutput("duty_ff_high", 32'(n), 32'd768);
        countHigh(2, 768, n);
        checkOutput("duty_00_high", 32'(n), 32'd0);

        $display("[TB] prescale 3");
        applyStimulus(1'b1, 1, 4'b1111, 32'h3, rdat);
        applyStimulus(1'b1, 4, 4'b1111, 32'h80, rdat);
        repeat (1200) @(negedge clk);
        countHigh(0, 1024, n);
        checkOutput("pre3_high", 32'(n), 32'd512);
        n = 0;
        while (m_pcnt != 1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pcnt_sync", 32'(m_pcnt), 32'd1);
        applyStimulus(1'b1, 1, 4'b1111, 32'h0, rdat);

        $display("[TB] blink");
        applyStimulus(1'b1, 4, 4'b1111, 32'hFF, rdat);
        applyStimulus(1'b1, 2, 4'b1111, 32'h2, rdat);
        applyStimulus(1'b1, 0, 4'b1111, 32'h3, rdat);
        repeat (600) @(negedge clk);
        countHigh(0, 2048, n);
        checkOutput("blink_high", 32'(n), 32'd1024);
        applyStimulus(1'b0, 3, 4'h0, 32'h0, rdat);
        checkOutput("blink_status", rdat, 32'(m_phase));
        applyStimulus(1'b1, 2, 4'b1111, 32'h0, rdat);
        repeat (4) @(negedge clk);
        countHigh(0, 300, n);
        checkOutput("blink_off_high", 32'(n), 32'd300);

        $display("[TB] byte lanes and reset during ack");
        applyStimulus(1'b1, 0, 4'b1111, 32'h1, rdat);
        applyStimulus(1'b1, 0, 4'b0000, 32'h3, rdat);
        applyStimulus(1'b0, 0, 4'h0, 32'h0, rdat);
        checkOutput("sel_none_ctrl", rdat, 32'd1);
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = ADR_W'(1);
        @(negedge clk);
        checkOutput("rst_ack_pre", 32'(bus.wb_ack_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_ack_drop", 32'(bus.wb_ack_o), 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        rst = 1'b0;
        for (int a = 0; a < 6; a++) begin
            applyStimulus(1'b0, a, 4'h0, 32'h0, rdat);
            checkOutput($sformatf("post_rst_rd%0d", a), rdat, (a == 3) ? 32'd1 : 32'd0);
        end

        $display("[TB] random traffic");
        for (int k = 0; k < 150; k++) begin
            adr = $urandom_range(0, 15);
            we  = 1'($urandom_range(0, 1));
            sel = 4'($urandom);
            dat = $urandom;
            if (adr == 1) dat = dat & 32'h7;
            if (adr == 2) dat = dat & 32'h3;
            applyStimulus(we, adr, sel, dat, rdat);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
